prio_encoder_rr: RTL and testbench
==================================

// Module: prio_encoder_rr
// PURPOSE
//  Parametrised, registered successor to the 3-bit encoder test block.
//  Accepts an N-bit request vector over a valid/ready handshake.
//  Returns three results one cycle later:
//   - winning index (fixed MSB-first or round-robin priority)
//   - one-hot grant
//   - population count of the request
//  Sits between request sources and any downstream arbiter or consumer that can stall.
// PARAMETERS
//  N        8   request vector width; N >= 2, need not be a power of two
//  RR_MODE  0   0 = fixed priority (highest index wins); 1 = round-robin
//  localparam IDX_W = $clog2(N)   index width (3 for N=8)
//  localparam CNT_W = $clog2(N+1) count width (4 for N=8)
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous reset, active-high
//  req_valid     in   1      request vector present
//  req_ready     out  1      block can accept a request this cycle
//  req           in   N      request bits
//  grant_valid   out  1      result registers hold a valid result
//  grant_ready   in   1      consumer takes the result this cycle
//  grant_idx     out  IDX_W  winning bit index
//  grant_onehot  out  N      1 << grant_idx; all-zero when grant_none
//  grant_none    out  1      accepted request vector was all-zero
//  req_count     out  CNT_W  number of set bits in the accepted request
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - grant_valid=0, grant_idx=0, grant_onehot=0, grant_none=0, req_count=0.
//   - RR pointer ptr=0.
//  Handshake:
//   - req_ready = !grant_valid || grant_ready (combinational).
//   - accept = req_valid && req_ready.
//  Accept:
//   - On accept, at the next edge all result registers load and grant_valid=1. Latency = 1 cycle.
//   - grant_valid clears only when grant_ready=1 with no new accept in the same cycle.
//   - Result registers are held stable while grant_valid=1 and grant_ready=0.
//   - Back-to-back: grant_ready=1 together with accept gives full throughput, one result per cycle.
//  Fixed mode (RR_MODE=0): the highest set index wins.
//  Round-robin mode (RR_MODE=1):
//   - Search starts at ptr and moves upward, wrapping N-1 -> 0; the first set bit wins.
//   - On accept with req != 0: ptr <= (win+1 == N) ? 0 : win+1.
//   - On accept with req == 0, and when not accepting: ptr is unchanged.
//  Zero request: grant_none=1, grant_idx=0, grant_onehot=0, req_count=0. grant_valid still asserts.
//  All-ones request: req_count=N; this needs CNT_W bits, so there is no overflow.
//  Reset mid-operation: a pending result is dropped immediately (grant_valid=0) and ptr returns to 0.
//  req is sampled only on accept; changes to req while not accepting have no effect.
// STRUCTURE
//  Shared include prio_defs.vh holds:
//   - IDX_W and CNT_W derivation macros
//   - mode constants PRIO_FIXED=0 and PRIO_RR=1
//  One combinational sub-module, prio_find (N, RR_MODE).
//   - Inputs: req, ptr.  Outputs: win_idx, found.
//   - RR is implemented as a rotate by ptr, a fixed search, then an index add modulo N.
//  Popcount is an adder tree in the top level.
//  Output and pointer registers are in the top level.
// TESTING
//  1 Fixed, N=8: accept req=8'b0010_0110
//    -> next cycle idx=5, onehot=8'b0010_0000, count=3, none=0.
//  2 Fixed: accept req=8'h00
//    -> valid=1, none=1, idx=0, onehot=0, count=0.
//  3 RR, ptr=0: req=8'b1000_0001 accepted 3x back-to-back, grant_ready=1
//    -> idx 0,7,0; ptr 1,0,1; no bubbles.
//  4 RR, ptr=7: accept req=8'b0000_0110
//    -> idx=1 (wrap); ptr=2.
//  5 Backpressure: hold grant_ready=0 with grant_valid=1
//    -> req_ready=0, outputs and ptr frozen for 5 cycles.
//    Then grant_ready=1 with req_valid=1 -> new result next cycle.
//  6 Assert rst mid-stream with grant_valid=1
//    -> grant_valid=0 before the next edge, ptr=0.
//    First RR request 8'hFF after release -> idx=0.
//    Also run N=3 (fixed): req=3'b111 -> idx=2, count=3.

Source files
------------

// File: rtl/prio_encoder_rr_pkg.sv
// ============================================================================
//  Module      : prio_encoder_rr_pkg
//  Description : Shared constants and width helpers for the priority encoder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package prio_encoder_rr_pkg;

    // Priority modes selectable through RR_MODE
    localparam int C_PRIO_FIXED = 0;
    localparam int C_PRIO_RR    = 1;

    // Index width for an n-bit request vector
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Count width able to hold the value n itself
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage : prio_encoder_rr_pkg

`default_nettype wire

// File: rtl/prio_find.sv
// ============================================================================
//  Module      : prio_find
//  Description : Combinational winner search, fixed MSB-first or round-robin.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_find
    import prio_encoder_rr_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = C_PRIO_FIXED,
    localparam int IDX_W   = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             found
);

    assign found = |req;

    generate
        if (RR_MODE == C_PRIO_RR) begin : g_rr
            logic [N-1:0]     w_rot;
            logic [IDX_W-1:0] w_off;
            logic [IDX_W:0]   w_sum;

            // Rotating a doubled copy keeps the wrap correct for any N, not only powers of two.
            assign w_rot = N'({req, req} >> ptr);

            always_comb begin
                w_off = '0;
                for (int i = N - 1; i >= 0; i--) begin
                    if (w_rot[i]) begin
                        w_off = IDX_W'(i);
                    end
                end
            end

            assign w_sum   = {1'b0, w_off} + {1'b0, ptr};
            assign win_idx = (w_sum >= (IDX_W + 1)'(N)) ? IDX_W'(w_sum - (IDX_W + 1)'(N))
                                                        : w_sum[IDX_W-1:0];
        end else begin : g_fixed
            logic [IDX_W-1:0] w_hi;
            logic             w_ptr_unused;

            assign w_ptr_unused = ^ptr;

            always_comb begin
                w_hi = '0;
                for (int i = 0; i < N; i++) begin
                    if (req[i]) begin
                        w_hi = IDX_W'(i);
                    end
                end
            end

            assign win_idx = w_hi;
        end
    endgenerate

endmodule : prio_find

`default_nettype wire

// File: rtl/prio_encoder_rr.sv
// ============================================================================
//  Module      : prio_encoder_rr
//  Description : Registered N-bit priority encoder with grant, one-hot and
//                popcount results behind a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_encoder_rr
    import prio_encoder_rr_pkg::*;
#(
    parameter  int N       = 8,
    parameter  int RR_MODE = C_PRIO_FIXED,
    localparam int IDX_W   = idx_width(N),
    localparam int CNT_W   = cnt_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N-1:0]     req,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot,
    output logic             grant_none,
    output logic [CNT_W-1:0] req_count
);

    localparam int C_LVLS = $clog2(N);
    localparam int C_P    = 1 << C_LVLS;

    logic             w_accept;
    logic             w_found;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_ptr;
    logic [CNT_W-1:0] w_count;

    logic             r_grant_valid;
    logic [IDX_W-1:0] r_idx;
    logic [N-1:0]     r_onehot;
    logic             r_none;
    logic [CNT_W-1:0] r_count;

    assign req_ready = !r_grant_valid || grant_ready;
    assign w_accept  = req_valid && req_ready;

    prio_find #(
        .N       (N),
        .RR_MODE (RR_MODE)
    ) u_find (
        .req     (req),
        .ptr     (w_ptr),
        .win_idx (w_win_idx),
        .found   (w_found)
    );

    // Pairwise adder tree; leaves beyond N are padded with zero.
    genvar l, k;
    generate
        for (l = 0; l <= C_LVLS; l++) begin : g_lvl
            logic [CNT_W-1:0] w_sum [C_P >> l];
            for (k = 0; k < (C_P >> l); k++) begin : g_node
                if (l == 0) begin : g_leaf
                    if (k < N) begin : g_bit
                        assign w_sum[k] = CNT_W'(req[k]);
                    end else begin : g_pad
                        assign w_sum[k] = '0;
                    end
                end else begin : g_add
                    assign w_sum[k] = g_lvl[l-1].w_sum[2*k] + g_lvl[l-1].w_sum[2*k+1];
                end
            end
        end
    endgenerate

    assign w_count = g_lvl[C_LVLS].w_sum[0];

    generate
        if (RR_MODE == C_PRIO_RR) begin : g_ptr
            logic [IDX_W-1:0] r_ptr;
            logic [IDX_W:0]   w_next;

            assign w_next = {1'b0, w_win_idx} + (IDX_W + 1)'(1);

            // An all-zero accepted request leaves the pointer where it was.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= '0;
                end else if (w_accept && w_found) begin
                    r_ptr <= (w_next == (IDX_W + 1)'(N)) ? '0 : w_next[IDX_W-1:0];
                end
            end

            assign w_ptr = r_ptr;
        end else begin : g_no_ptr
            assign w_ptr = '0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_valid <= 1'b0;
            r_idx         <= '0;
            r_onehot      <= '0;
            r_none        <= 1'b0;
            r_count       <= '0;
        end else if (w_accept) begin
            r_grant_valid <= 1'b1;
            r_idx         <= w_found ? w_win_idx : '0;
            r_onehot      <= w_found ? (N'(1) << w_win_idx) : '0;
            r_none        <= !w_found;
            r_count       <= w_count;
        end else if (grant_ready) begin
            r_grant_valid <= 1'b0;
        end
    end

    assign grant_valid  = r_grant_valid;
    assign grant_idx    = r_idx;
    assign grant_onehot = r_onehot;
    assign grant_none   = r_none;
    assign req_count    = r_count;

endmodule : prio_encoder_rr

`default_nettype wire

// File: tb/tb_prio_encoder_rr.sv
// ============================================================================
//  Module      : tb_prio_encoder_rr
//  Description : Self-checking bench: fixed N=8, round-robin N=8, fixed N=3.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prio_encoder_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       grant_ready;
    logic [7:0] req;

    always #5 clk = ~clk;

    logic       rdy0, gv0, gn0, rdy1, gv1, gn1, rdy2, gv2, gn2;
    logic [2:0] gi0, gi1;
    logic [1:0] gi2;
    logic [7:0] oh0, oh1;
    logic [2:0] oh2;
    logic [3:0] cnt0, cnt1;
    logic [1:0] cnt2;

    prio_encoder_rr #(.N(8), .RR_MODE(0)) u_fix8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy0), .req(req),
        .grant_valid(gv0), .grant_ready(grant_ready), .grant_idx(gi0),
        .grant_onehot(oh0), .grant_none(gn0), .req_count(cnt0));

    prio_encoder_rr #(.N(8), .RR_MODE(1)) u_rr8 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req(req),
        .grant_valid(gv1), .grant_ready(grant_ready), .grant_idx(gi1),
        .grant_onehot(oh1), .grant_none(gn1), .req_count(cnt1));

    prio_encoder_rr #(.N(3), .RR_MODE(0)) u_fix3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req(req[2:0]),
        .grant_valid(gv2), .grant_ready(grant_ready), .grant_idx(gi2),
        .grant_onehot(oh2), .grant_none(gn2), .req_count(cnt2));

    logic       obs_rdy [3];
    logic       obs_gv  [3];
    logic       obs_none[3];
    logic [7:0] obs_idx [3];
    logic [7:0] obs_oh  [3];
    logic [7:0] obs_cnt [3];

    assign obs_rdy[0] = rdy0;  assign obs_rdy[1] = rdy1;  assign obs_rdy[2] = rdy2;
    assign obs_gv[0]  = gv0;   assign obs_gv[1]  = gv1;   assign obs_gv[2]  = gv2;
    assign obs_none[0] = gn0;  assign obs_none[1] = gn1;  assign obs_none[2] = gn2;
    assign obs_idx[0] = {5'b0, gi0};  assign obs_idx[1] = {5'b0, gi1};  assign obs_idx[2] = {6'b0, gi2};
    assign obs_oh[0]  = oh0;          assign obs_oh[1]  = oh1;          assign obs_oh[2]  = {5'b0, oh2};
    assign obs_cnt[0] = {4'b0, cnt0}; assign obs_cnt[1] = {4'b0, cnt1}; assign obs_cnt[2] = {6'b0, cnt2};

    int checks   = 0;
    int failures = 0;

    // Reference model state, one slot per instance
    logic m_valid[3];
    logic m_none [3];
    int   m_idx  [3];
    int   m_oh   [3];
    int   m_cnt  [3];
    int   m_ptr  [3];
    logic exp_rdy[3];
    logic got_rdy[3];

    function automatic int cfg_n(input int d);
        return (d == 2) ? 3 : 8;
    endfunction

    function automatic bit cfg_rr(input int d);
        return d == 1;
    endfunction

    // Winner straight from the priority rules: scan upward from ptr, or take the top bit.
    function automatic int ref_win(input int n, input bit rr, input int ptr, input logic [7:0] rq);
        if (rr) begin
            for (int s = 0; s < n; s++) begin
                if (rq[(ptr + s) % n]) return (ptr + s) % n;
            end
        end else begin
            for (int b = n - 1; b >= 0; b--) begin
                if (rq[b]) return b;
            end
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_valid[d] = 1'b0; m_none[d] = 1'b0;
            m_idx[d] = 0; m_oh[d] = 0; m_cnt[d] = 0; m_ptr[d] = 0;
        end
    endtask

    // Drives one cycle from just after a rising edge and advances the model across that edge.
    task automatic drive_cycle(input logic v, input logic [7:0] r, input logic gr);
        logic [7:0] rq;
        int         n;
        int         w;
        req_valid = v; req = r; grant_ready = gr;
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_rdy[d] = !m_valid[d] || gr;
            got_rdy[d] = obs_rdy[d];
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            n  = cfg_n(d);
            rq = r & 8'((1 << n) - 1);
            if (v && exp_rdy[d]) begin
                m_valid[d] = 1'b1;
                m_cnt[d]   = $countones(rq);
                if (rq == 8'd0) begin
                    m_none[d] = 1'b1; m_idx[d] = 0; m_oh[d] = 0;
                end else begin
                    w = ref_win(n, cfg_rr(d), m_ptr[d], rq);
                    m_none[d] = 1'b0; m_idx[d] = w; m_oh[d] = 1 << w;
                    if (cfg_rr(d)) m_ptr[d] = (w + 1) % n;
                end
            end else if (gr) begin
                m_valid[d] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req = 8'd0; grant_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({obs_gv[d], obs_none[d], obs_idx[d], obs_oh[d], obs_cnt[d]} !== 26'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d: got %h required 0", d,
                         {obs_gv[d], obs_none[d], obs_idx[d], obs_oh[d], obs_cnt[d]});
            end
            checks++;
            if (obs_rdy[d] !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready dut%0d: got %b required 1", d, obs_rdy[d]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_directed();
        logic [7:0] seq_req[6];
        int         seq_idx[6];
        seq_req = '{8'h81, 8'h81, 8'h81, 8'h40, 8'h06, 8'hFF};
        seq_idx = '{0, 7, 0, 6, 1, 2};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, seq_req[i], 1'b1);
            checks++;
            if (got_rdy[1] !== 1'b1) begin
                failures++;
                $display("FAIL rr_no_bubble step%0d: ready %b required 1", i, got_rdy[1]);
            end
            checks++;
            if (gv1 !== 1'b1 || gi1 !== 3'(seq_idx[i])) begin
                failures++;
                $display("FAIL rr_idx step%0d: valid %b idx %0d required valid 1 idx %0d",
                         i, gv1, gi1, seq_idx[i]);
            end
        end
    endtask

    task automatic test_fixed_directed();
        drive_cycle(1'b1, 8'b0010_0110, 1'b1);
        checks++;
        if ({gv0, gn0, gi0, oh0, cnt0} !== {1'b1, 1'b0, 3'd5, 8'h20, 4'd3}) begin
            failures++;
            $display("FAIL fixed_0x26: got v%b n%b i%0d oh%h c%0d required v1 n0 i5 oh20 c3",
                     gv0, gn0, gi0, oh0, cnt0);
        end
        drive_cycle(1'b1, 8'h00, 1'b1);
        checks++;
        if ({gv0, gn0, gi0, oh0, cnt0} !== {1'b1, 1'b1, 3'd0, 8'h00, 4'd0}) begin
            failures++;
            $display("FAIL fixed_zero: got v%b n%b i%0d oh%h c%0d required v1 n1 i0 oh00 c0",
                     gv0, gn0, gi0, oh0, cnt0);
        end
        checks++;
        if ({gv1, gn1, gi1, oh1, cnt1} !== {1'b1, 1'b1, 3'd0, 8'h00, 4'd0}) begin
            failures++;
            $display("FAIL rr_zero: got v%b n%b i%0d oh%h c%0d required v1 n1 i0 oh00 c0",
                     gv1, gn1, gi1, oh1, cnt1);
        end
        drive_cycle(1'b1, 8'hFF, 1'b1);
        checks++;
        if ({gn0, gi0, oh0, cnt0} !== {1'b0, 3'd7, 8'h80, 4'd8}) begin
            failures++;
            $display("FAIL fixed_all_ones: got n%b i%0d oh%h c%0d required n0 i7 oh80 c8",
                     gn0, gi0, oh0, cnt0);
        end
        checks++;
        if ({gv2, gi2, oh2, cnt2} !== {1'b1, 2'd2, 3'b100, 2'd3}) begin
            failures++;
            $display("FAIL n3_all_ones: got v%b i%0d oh%b c%0d required v1 i2 oh100 c3",
                     gv2, gi2, oh2, cnt2);
        end
        drive_cycle(1'b0, 8'h00, 1'b1);
        checks++;
        if ({gv0, gv1, gv2} !== 3'b000) begin
            failures++;
            $display("FAIL valid_clear: got %b required 000", {gv0, gv1, gv2});
        end
    endtask

    task automatic test_backpressure();
        drive_cycle(1'b1, 8'h3C, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 8'($urandom), 1'b0);
            checks++;
            if (got_rdy[0] !== 1'b0) begin
                failures++;
                $display("FAIL bp_ready cycle%0d: got %b required 0", i, got_rdy[0]);
            end
            checks++;
            if ({gv0, gn0, gi0, oh0, cnt0} !== {1'b1, 1'b0, 3'd5, 8'h20, 4'd4}) begin
                failures++;
                $display("FAIL bp_hold cycle%0d: got v%b n%b i%0d oh%h c%0d required v1 n0 i5 oh20 c4",
                         i, gv0, gn0, gi0, oh0, cnt0);
            end
            checks++;
            if (gv1 !== 1'b1 || gi1 !== 3'(m_idx[1])) begin
                failures++;
                $display("FAIL bp_rr_hold cycle%0d: got v%b i%0d required v1 i%0d", i, gv1, gi1, m_idx[1]);
            end
        end
        drive_cycle(1'b1, 8'h01, 1'b1);
        checks++;
        if (got_rdy[0] !== 1'b1 || {gv0, gi0, cnt0} !== {1'b1, 3'd0, 4'd1}) begin
            failures++;
            $display("FAIL bp_release: got rdy%b v%b i%0d c%0d required rdy1 v1 i0 c1",
                     got_rdy[0], gv0, gi0, cnt0);
        end
        drive_cycle(1'b1, 8'hFF, 1'b1);
        checks++;
        if (gi1 !== 3'(m_idx[1])) begin
            failures++;
            $display("FAIL bp_rr_ptr: got idx %0d required %0d", gi1, m_idx[1]);
        end
    endtask

    task automatic test_reset_midstream();
        drive_cycle(1'b1, 8'h10, 1'b1);
        drive_cycle(1'b0, 8'h00, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({gv0, gv1, gv2} !== 3'b000) begin
            failures++;
            $display("FAIL midreset_valid: got %b required 000", {gv0, gv1, gv2});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive_cycle(1'b1, 8'hFF, 1'b1);
        checks++;
        if (gi1 !== 3'd0) begin
            failures++;
            $display("FAIL midreset_rr_first: got idx %0d required 0", gi1);
        end
        drive_cycle(1'b1, 8'hFF, 1'b1);
        checks++;
        if (gi1 !== 3'd1) begin
            failures++;
            $display("FAIL midreset_rr_second: got idx %0d required 1", gi1);
        end
    endtask

    task automatic test_random();
        logic       v;
        logic       gr;
        logic [7:0] r;
        for (int it = 0; it < 300; it++) begin
            v  = ($urandom_range(0, 3) != 0);
            gr = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0:       r = 8'h00;
                1:       r = 8'hFF;
                default: r = 8'($urandom);
            endcase
            drive_cycle(v, r, gr);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (got_rdy[d] !== exp_rdy[d] || obs_gv[d] !== m_valid[d]) begin
                    failures++;
                    $display("FAIL rand_handshake it%0d dut%0d: rdy %b valid %b required rdy %b valid %b",
                             it, d, got_rdy[d], obs_gv[d], exp_rdy[d], m_valid[d]);
                end
                if (m_valid[d]) begin
                    checks++;
                    if ({obs_none[d], obs_idx[d], obs_oh[d], obs_cnt[d]} !==
                        {m_none[d], 8'(m_idx[d]), 8'(m_oh[d]), 8'(m_cnt[d])}) begin
                        failures++;
                        $display("FAIL rand_result it%0d dut%0d: n%b i%0d oh%h c%0d required n%b i%0d oh%h c%0d",
                                 it, d, obs_none[d], obs_idx[d], obs_oh[d], obs_cnt[d],
                                 m_none[d], m_idx[d], m_oh[d], m_cnt[d]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_directed();
        test_fixed_directed();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_prio_encoder_rr

`default_nettype wire
